// File: rtl/spi_txn_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter_if
//   Bundles the two requester ports and the SPI byte-transmitter control port
//   served by spi_txn_arbiter.
//
//   Requester N (N = 0 init/config, N = 1 status/volume):
//     reqN, instN[7:0], rdwrN, addrN[7:0], wdatN[7:0]   requester -> arbiter
//     ackN, doneN, rdatN[7:0], errN                      arbiter -> requester
//   Transmitter:
//     tx_ready, tx_inst[7:0], tx_rdh_wrl,
//     tx_reg_addr[7:0], tx_dout[7:0]                     arbiter -> transmitter
//     tx_din[7:0], tx_din_valid, tx_csn                  transmitter -> arbiter
//   Status:
//     busy                                               arbiter -> system
//
//   Modports: slave = arbiter side, master = requesters/transmitter side.
// -----------------------------------------------------------------------------
interface spi_txn_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] inst0;
    logic [7:0] inst1;
    logic       rdwr0;
    logic       rdwr1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdat0;
    logic [7:0] wdat1;

    logic       ack0;
    logic       ack1;
    logic       done0;
    logic       done1;
    logic [7:0] rdat0;
    logic [7:0] rdat1;
    logic       err0;
    logic       err1;

    logic       tx_ready;
    logic [7:0] tx_inst;
    logic       tx_rdh_wrl;
    logic [7:0] tx_reg_addr;
    logic [7:0] tx_dout;
    logic [7:0] tx_din;
    logic       tx_din_valid;
    logic       tx_csn;

    logic       busy;

    modport slave (
        input  req0, req1, inst0, inst1, rdwr0, rdwr1,
               addr0, addr1, wdat0, wdat1,
               tx_din, tx_din_valid, tx_csn,
        output ack0, ack1, done0, done1, rdat0, rdat1, err0, err1,
               tx_ready, tx_inst, tx_rdh_wrl, tx_reg_addr, tx_dout,
               busy
    );

    modport master (
        output req0, req1, inst0, inst1, rdwr0, rdwr1,
               addr0, addr1, wdat0, wdat1,
               tx_din, tx_din_valid, tx_csn,
        input  ack0, ack1, done0, done1, rdat0, rdat1, err0, err1,
               tx_ready, tx_inst, tx_rdh_wrl, tx_reg_addr, tx_dout,
               busy
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
//   Round-robin arbiter and sequencer in front of the SPI byte transmitter used
//   for decoder register access. One instruction+address+data transaction is
//   run at a time; completion is taken from the SPI chip-select line returning
//   high, and read data or an error is reported back to the owning requester.
//
//   Parameters:
//     TIMEOUT_CYCLES  clk cycles allowed from tx_ready rise to tx_csn high
//     GAP_CYCLES      clk cycles tx_ready is held low between transactions (>=2)
//
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active high
//     bus   spi_txn_arbiter_if.slave (requester ports, transmitter port, busy)
// -----------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_txn_arbiter_if.slave   bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_FINISH,
        S_ABORT,
        S_GAP
    } state_e;

    state_e        state_q, state_d;
    // Port of the most recent grant; also identifies the owner of the
    // transaction in flight.
    logic          last_grant_q, last_grant_d;
    logic [7:0]    tx_inst_q, tx_inst_d;
    logic          tx_rdwr_q, tx_rdwr_d;
    logic [7:0]    tx_addr_q, tx_addr_d;
    logic [7:0]    tx_dout_q, tx_dout_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          got_q, got_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    rdat0_q, rdat0_d;
    logic [7:0]    rdat1_q, rdat1_d;

    logic          grant_sel;
    logic          timer_exp;
    logic          got_now;
    logic [7:0]    data_now;

    // Tie goes to the port that did not win last time.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = bus.req1;
        end
    end

    assign timer_exp = (timer_q == TIMER_MAX);

    // A din_valid coinciding with the chip-select rise still counts as data.
    assign got_now  = got_q | bus.tx_din_valid;
    assign data_now = bus.tx_din_valid ? bus.tx_din : data_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tx_inst_d    = tx_inst_q;
        tx_rdwr_d    = tx_rdwr_q;
        tx_addr_d    = tx_addr_q;
        tx_dout_d    = tx_dout_q;
        timer_d      = timer_q;
        gap_d        = gap_q;
        got_d        = got_q;
        data_d       = data_q;
        rdat0_d      = rdat0_q;
        rdat1_d      = rdat1_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Fields are captured here so they are already stable
                    // on the transmitter port while ack is shown in LOAD.
                    last_grant_d = grant_sel;
                    if (grant_sel) begin
                        tx_inst_d = bus.inst1;
                        tx_rdwr_d = bus.rdwr1;
                        tx_addr_d = bus.addr1;
                        tx_dout_d = bus.wdat1;
                    end else begin
                        tx_inst_d = bus.inst0;
                        tx_rdwr_d = bus.rdwr0;
                        tx_addr_d = bus.addr0;
                        tx_dout_d = bus.wdat0;
                    end
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                got_d   = 1'b0;
                timer_d = '0;
                state_d = S_START;
            end

            S_START: begin
                if (!timer_exp) begin
                    timer_d = timer_q + 1'b1;
                end
                if (!bus.tx_csn) begin
                    state_d = S_RUN;
                end else if (timer_exp) begin
                    state_d = S_ABORT;
                end
            end

            S_RUN: begin
                if (!timer_exp) begin
                    timer_d = timer_q + 1'b1;
                end
                if (bus.tx_din_valid) begin
                    data_d = bus.tx_din;
                    got_d  = 1'b1;
                end
                if (bus.tx_csn) begin
                    // rdat is updated on entry to FINISH so it is valid
                    // alongside the done pulse.
                    if (tx_rdwr_q && got_now) begin
                        if (last_grant_q) begin
                            rdat1_d = data_now;
                        end else begin
                            rdat0_d = data_now;
                        end
                    end
                    state_d = S_FINISH;
                end else if (timer_exp) begin
                    state_d = S_ABORT;
                end
            end

            S_FINISH: begin
                gap_d   = '0;
                state_d = S_GAP;
            end

            S_ABORT: begin
                gap_d   = '0;
                state_d = S_GAP;
            end

            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            tx_inst_q    <= '0;
            tx_rdwr_q    <= 1'b0;
            tx_addr_q    <= '0;
            tx_dout_q    <= '0;
            timer_q      <= '0;
            gap_q        <= '0;
            got_q        <= 1'b0;
            data_q       <= '0;
            rdat0_q      <= '0;
            rdat1_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tx_inst_q    <= tx_inst_d;
            tx_rdwr_q    <= tx_rdwr_d;
            tx_addr_q    <= tx_addr_d;
            tx_dout_q    <= tx_dout_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            got_q        <= got_d;
            data_q       <= data_d;
            rdat0_q      <= rdat0_d;
            rdat1_q      <= rdat1_d;
        end
    end

    // Handshake outputs are decoded from state, so they drop to zero in the
    // same cycle that reset is asserted.
    logic in_load;
    logic in_done;
    logic err_now;

    assign in_load = (state_q == S_LOAD);
    assign in_done = (state_q == S_FINISH) || (state_q == S_ABORT);
    assign err_now = (state_q == S_ABORT) ||
                     ((state_q == S_FINISH) && tx_rdwr_q && !got_q);

    assign bus.ack0        = in_load && !last_grant_q;
    assign bus.ack1        = in_load &&  last_grant_q;
    assign bus.done0       = in_done && !last_grant_q;
    assign bus.done1       = in_done &&  last_grant_q;
    assign bus.err0        = err_now && !last_grant_q;
    assign bus.err1        = err_now &&  last_grant_q;
    assign bus.rdat0       = rdat0_q;
    assign bus.rdat1       = rdat1_q;

    assign bus.tx_ready    = (state_q == S_START) || (state_q == S_RUN);
    assign bus.tx_inst     = tx_inst_q;
    assign bus.tx_rdh_wrl  = tx_rdwr_q;
    assign bus.tx_reg_addr = tx_addr_q;
    assign bus.tx_dout     = tx_dout_q;

    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;

    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned GAP     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_txn_arbiter_if bus();

    spi_txn_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [48:0] all_outs;
    assign all_outs = {bus.ack0, bus.ack1, bus.done0, bus.done1,
                       bus.rdat0, bus.rdat1, bus.err0, bus.err1,
                       bus.tx_ready, bus.tx_inst, bus.tx_rdh_wrl,
                       bus.tx_reg_addr, bus.tx_dout, bus.busy};

    typedef struct {
        bit         port;
        logic [7:0] inst;
        bit         rdwr;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] din;
        int         mode;      // 0 no din_valid, 1 mid-RUN pulse, 2 pulse with csn rise
        bit         exp_err;
        logic [7:0] exp_rdat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        if (v.port) begin
            bus.req1 = 1'b1; bus.inst1 = v.inst; bus.rdwr1 = v.rdwr;
            bus.addr1 = v.addr; bus.wdat1 = v.wdat;
        end else begin
            bus.req0 = 1'b1; bus.inst0 = v.inst; bus.rdwr0 = v.rdwr;
            bus.addr0 = v.addr; bus.wdat0 = v.wdat;
        end
    endtask

    task automatic scramble;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.inst0 = 8'hFF; bus.inst1 = 8'hFF; bus.rdwr0 = 1'b0; bus.rdwr1 = 1'b0;
        bus.addr0 = 8'hEE; bus.addr1 = 8'hEE; bus.wdat0 = 8'hDD; bus.wdat1 = 8'hDD;
    endtask

    // Issue a request and walk it to START, checking ack latency and fields.
    // Returns at the negedge of the first START cycle.
    task automatic issue_to_start(input vec_t v);
        logic [24:0] fields;
        fields = {v.inst, v.rdwr, v.addr, v.wdat};
        tick;
        drive_req(v);
        @(negedge clk);
        chk("ack_early", 64'({bus.ack0, bus.ack1}), 64'(0));
        tick;
        @(negedge clk);
        chk("ack_port", 64'({bus.ack0, bus.ack1}), v.port ? 64'(2'b01) : 64'(2'b10));
        chk("load_fields", 64'({bus.tx_inst, bus.tx_rdh_wrl, bus.tx_reg_addr, bus.tx_dout}), 64'(fields));
        chk("load_rdy", 64'(bus.tx_ready), 64'(0));
        scramble;
        tick;
        @(negedge clk);
        chk("start_rdy", 64'(bus.tx_ready), 64'(1));
        chk("start_ack", 64'({bus.ack0, bus.ack1}), 64'(0));
        chk("start_fields", 64'({bus.tx_inst, bus.tx_rdh_wrl, bus.tx_reg_addr, bus.tx_dout}), 64'(fields));
    endtask

    task automatic respond(input int mode, input logic [7:0] din);
        tick;
        bus.tx_csn = 1'b0;
        tick;
        tick;
        if (mode == 1) begin
            bus.tx_din = din; bus.tx_din_valid = 1'b1;
            tick;
            bus.tx_din_valid = 1'b0;
            tick;
            bus.tx_csn = 1'b1;
        end else if (mode == 2) begin
            bus.tx_din = din; bus.tx_din_valid = 1'b1; bus.tx_csn = 1'b1;
            tick;
            bus.tx_din_valid = 1'b0;
        end else begin
            tick;
            bus.tx_csn = 1'b1;
        end
    endtask

    task automatic wait_done(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            n++;
            if (bus.done0 || bus.done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the done negedge; counts busy cycles until IDLE.
    task automatic check_gap;
        int  n;
        bit  rdy;
        n   = 0;
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            rdy = rdy | bus.tx_ready;
        end
        chk("gap_len", 64'(n), 64'(GAP));
        chk("gap_rdy_low", 64'(rdy), 64'(0));
    endtask

    task automatic do_vec(input vec_t v);
        int n;
        bit ok;
        issue_to_start(v);
        respond(v.mode, v.din);
        wait_done(20, n, ok);
        chk("done_seen", 64'(ok), 64'(1));
        chk("done_port", 64'({bus.done0, bus.done1}), v.port ? 64'(2'b01) : 64'(2'b10));
        chk("err", 64'({bus.err0, bus.err1}), v.port ? 64'({1'b0, v.exp_err}) : 64'({v.exp_err, 1'b0}));
        chk("rdat", 64'(v.port ? bus.rdat1 : bus.rdat0), 64'(v.exp_rdat));
        chk("done_rdy", 64'(bus.tx_ready), 64'(0));
        check_gap;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      n;
        bit      ok;
        int      acc;
        bit      order[4];
        vec_t    v;

        //            port inst   rdwr addr   wdat   din    mode err rdat
        vecs[0] = '{1'b0, 8'h02, 1'b0, 8'h0B, 8'h20, 8'h00, 0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h03, 1'b1, 8'h01, 8'h00, 8'hA5, 1, 1'b0, 8'hA5};
        vecs[2] = '{1'b0, 8'h03, 1'b1, 8'h10, 8'h00, 8'h3C, 2, 1'b0, 8'h3C};
        vecs[3] = '{1'b1, 8'h03, 1'b1, 8'h22, 8'h00, 8'h00, 0, 1'b1, 8'hA5};
        vecs[4] = '{1'b0, 8'h02, 1'b0, 8'h05, 8'h5A, 8'h77, 1, 1'b0, 8'h3C};
        vecs[5] = '{1'b1, 8'h02, 1'b0, 8'hFF, 8'h00, 8'h00, 0, 1'b0, 8'hA5};

        scramble;
        bus.tx_din = 8'h00; bus.tx_din_valid = 1'b0; bus.tx_csn = 1'b1;

        // Reset state
        #12;
        chk("reset_outs", 64'(all_outs), 64'(0));
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", 64'(all_outs), 64'(0));

        // Request withdrawn before any IDLE sample: no ack, stays idle
        tick;
        bus.req0 = 1'b1;
        @(negedge clk);
        bus.req0 = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc = acc | {bus.ack0, bus.ack1, bus.busy};
        end
        chk("req_drop_noack", 64'(acc), 64'(0));

        // chip-select low and din_valid while idle are ignored
        tick;
        bus.tx_csn = 1'b0; bus.tx_din_valid = 1'b1; bus.tx_din = 8'h99;
        tick;
        bus.tx_din_valid = 1'b0;
        tick;
        @(negedge clk);
        chk("idle_csn_ignored", 64'(all_outs), 64'(0));
        bus.tx_csn = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            do_vec(vecs[i]);
        end

        // Timeout: chip select never goes low
        v = '{1'b0, 8'h02, 1'b0, 8'h40, 8'h11, 8'h00, 0, 1'b1, 8'h3C};
        issue_to_start(v);
        wait_done(TIMEOUT + 50, n, ok);
        chk("to_done_seen", 64'(ok), 64'(1));
        chk("to_latency", 64'(n), 64'(TIMEOUT + 1));
        chk("to_done_port", 64'({bus.done0, bus.done1}), 64'(2'b10));
        chk("to_err", 64'({bus.err0, bus.err1}), 64'(2'b10));
        chk("to_rdat", 64'(bus.rdat0), 64'(8'h3C));
        chk("to_rdy", 64'(bus.tx_ready), 64'(0));
        check_gap;

        // Reset asserted mid-RUN
        v = '{1'b1, 8'h03, 1'b1, 8'h07, 8'h00, 8'h00, 0, 1'b0, 8'h00};
        issue_to_start(v);
        tick;
        bus.tx_csn = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("run_rdy", 64'(bus.tx_ready), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 64'(all_outs), 64'(0));
        tick;
        tick;
        rst = 1'b0;
        bus.tx_csn = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = acc | {bus.done0, bus.done1, bus.busy};
        end
        chk("rst_no_done", 64'(acc), 64'(0));

        // Both requesters held high from reset: strict alternation, port 0 first
        tick;
        bus.req0 = 1'b1; bus.inst0 = 8'h02; bus.rdwr0 = 1'b0; bus.addr0 = 8'h01; bus.wdat0 = 8'h10;
        bus.req1 = 1'b1; bus.inst1 = 8'h02; bus.rdwr1 = 1'b0; bus.addr1 = 8'h02; bus.wdat1 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.ack0 || bus.ack1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("both_ack_seen", 64'(ok), 64'(1));
            order[k] = bus.ack1;
            chk("both_order", 64'(order[k]), 64'(k % 2));
            chk("both_addr", 64'(bus.tx_reg_addr), (k % 2 == 1) ? 64'(8'h02) : 64'(8'h01));
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            tick;
            @(negedge clk);
            respond(0, 8'h00);
            wait_done(20, n, ok);
            chk("both_done_seen", 64'(ok), 64'(1));
            chk("both_done_port", 64'({bus.done0, bus.done1}), order[k] ? 64'(2'b01) : 64'(2'b10));
            check_gap;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
